// File: rtl/ad7606_par_ctrl.sv
// ad7606_par_ctrl
// Sequencer for an AD7606 in parallel-read mode. It holds the ADC in reset
// after power-up, then runs conversion frames. A frame is CONVST, a fixed
// settle wait, a wait for BUSY to drop, then CH_NUM RD strobes with CS held low.
// Frames are started by start pulses or run back to back when cont_en is set.
//
// Ports
//   clk, rst             system clock, async active-high reset
//   start, cont_en       frame request pulse / free-running enable
//   os_cfg, range_cfg    OS and RANGE settings, applied only while idle
//   err_clr              clears the sticky error flags
//   ad_data/busy/first   ADC parallel bus and status inputs
//   ad_os/range/reset    ADC static configuration and RESET pins
//   ad_convst/cs/rd      ADC strobes, active low
//   dout, dout_ch        captured sample and its channel (0 = CH1)
//   dout_valid           one-cycle strobe for dout/dout_ch
//   frame_done           one-cycle pulse after a fully read frame
//   ctrl_busy            low only in IDLE
//   err_tmo, err_first   sticky BUSY-timeout / FRSTDATA-mismatch flags
//
// state      | meaning
// -----------+---------------------------------------------------------
// POR        | ad_reset high for T_RST cycles after reset release
// IDLE       | latch OS/RANGE; leave after T_IDLE cycles on a request
// CONV       | convst low for T_CONV cycles
// WAIT1      | T_WAIT cycles before busy is trusted
// WAIT_BUSY  | wait for busy low, give up after T_TMO cycles
// RD_LO      | cs and rd low; sample captured on the last cycle
// RD_HI      | cs low, rd high; next channel or finish
// DONE       | one cycle; frame_done if the frame completed

module ad7606_par_ctrl #(
  parameter int CH_NUM  = 8,
  parameter int T_RST   = 65535,
  parameter int T_IDLE  = 21,
  parameter int T_CONV  = 3,
  parameter int T_WAIT  = 6,
  parameter int T_RD_LO = 4,
  parameter int T_RD_HI = 2,
  parameter int T_TMO   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont_en,
  input  logic [2:0]  os_cfg,
  input  logic        range_cfg,
  input  logic        err_clr,
  input  logic [15:0] ad_data,
  input  logic        ad_busy,
  input  logic        ad_first,
  output logic [2:0]  ad_os,
  output logic        ad_range,
  output logic        ad_reset,
  output logic        ad_convst,
  output logic        ad_cs,
  output logic        ad_rd,
  output logic [15:0] dout,
  output logic [2:0]  dout_ch,
  output logic        dout_valid,
  output logic        frame_done,
  output logic        ctrl_busy,
  output logic        err_tmo,
  output logic        err_first
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = imax(imax(imax(T_RST, T_TMO), imax(T_IDLE, T_CONV)),
                                imax(T_WAIT, imax(T_RD_LO, T_RD_HI)));
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_POR, S_IDLE, S_CONV, S_WAIT1, S_WAIT_BUSY, S_RD_LO, S_RD_HI, S_DONE
  } state_t;

  state_t        st, st_n;
  logic [CW-1:0] cnt;
  logic [2:0]    ch;
  logic          pend;
  logic          idle_ok;
  logic          cap, tmo_set, done_ok, ch_inc, first_bad;

  // The idle counter saturates so a request arriving long after the frame
  // is honoured on the very next cycle.
  assign idle_ok   = (cnt == CW'(T_IDLE - 1));
  assign first_bad = cap && ((ch == 3'd0) ? !ad_first : ad_first);

  always_comb begin
    st_n    = st;
    cap     = 1'b0;
    tmo_set = 1'b0;
    done_ok = 1'b0;
    ch_inc  = 1'b0;
    case (st)
      S_POR:       if (cnt == CW'(T_RST - 1)) st_n = S_IDLE;
      S_IDLE:      if (idle_ok && (cont_en || pend || start)) st_n = S_CONV;
      S_CONV:      if (cnt == CW'(T_CONV - 1)) st_n = S_WAIT1;
      S_WAIT1:     if (cnt == CW'(T_WAIT - 1)) st_n = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!ad_busy) begin
          st_n = S_RD_LO;
        end else if (cnt == CW'(T_TMO - 1)) begin
          st_n    = S_DONE;
          tmo_set = 1'b1;
        end
      end
      S_RD_LO: begin
        if (cnt == CW'(T_RD_LO - 1)) begin
          st_n = S_RD_HI;
          cap  = 1'b1;
        end
      end
      S_RD_HI: begin
        if (cnt == CW'(T_RD_HI - 1)) begin
          if (ch == 3'(CH_NUM - 1)) begin
            st_n    = S_DONE;
            done_ok = 1'b1;
          end else begin
            st_n   = S_RD_LO;
            ch_inc = 1'b1;
          end
        end
      end
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_POR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= S_POR;
      cnt  <= '0;
      ch   <= '0;
      pend <= 1'b0;
    end else begin
      st <= st_n;
      if (st_n != st)
        cnt <= '0;
      else if (!(st == S_IDLE && idle_ok))
        cnt <= cnt + 1'b1;
      if (st == S_WAIT_BUSY && st_n == S_RD_LO)
        ch <= '0;
      else if (ch_inc)
        ch <= ch + 1'b1;
      // A start seen in IDLE is consumed by the IDLE->CONV move; any
      // other start (including several in one frame) leaves one request.
      if (st == S_IDLE && st_n == S_CONV)
        pend <= 1'b0;
      else if (start)
        pend <= 1'b1;
    end
  end

  // ADC pins are registered from the next state so they never glitch on
  // state-decode hazards and still line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_reset   <= 1'b1;
      ad_convst  <= 1'b1;
      ad_cs      <= 1'b1;
      ad_rd      <= 1'b1;
      ctrl_busy  <= 1'b1;
      ad_os      <= 3'b000;
      ad_range   <= 1'b1;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      err_tmo    <= 1'b0;
      err_first  <= 1'b0;
    end else begin
      ad_reset   <= (st_n == S_POR);
      ad_convst  <= (st_n != S_CONV);
      ad_cs      <= !(st_n == S_RD_LO || st_n == S_RD_HI);
      ad_rd      <= (st_n != S_RD_LO);
      ctrl_busy  <= (st_n != S_IDLE);
      if (st == S_IDLE) begin
        ad_os    <= os_cfg;
        ad_range <= range_cfg;
      end
      dout_valid <= cap;
      frame_done <= done_ok;
      if (cap) begin
        dout    <= ad_data;
        dout_ch <= ch;
      end
      // Setting takes priority over a simultaneous clear.
      err_tmo   <= tmo_set | (err_tmo & ~err_clr);
      err_first <= first_bad | (err_first & ~err_clr);
    end
  end

endmodule

// File: doc/ad7606_par_ctrl.md
AD7606_PAR_CTRL -- requirements
Module: ad7606_par_ctrl

Interface
REQ-001 Parameters: CH_NUM, 8, channels read per frame (1..8); T_RST, 65535, ad_reset high cycles after rst release; T_IDLE, 21, idle cycles between frames; T_CONV, 3, convst low cycles; T_WAIT, 6, cycles before busy sampled; T_RD_LO, 4, rd low cycles; T_RD_HI, 2, rd high cycles between reads; T_TMO, 4096, busy timeout cycles.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-frame request, one-cycle pulse
- cont_en  in  1  1 = free-running frames, 0 = frame per start
- os_cfg  in  3  oversampling ratio code
- range_cfg  in  1  1 = +/-10 V, 0 = +/-5 V
- err_clr  in  1  clears sticky error flags
- ad_data  in  16  ADC parallel data
- ad_busy  in  1  ADC busy
- ad_first  in  1  ADC first-data flag
- ad_os  out  3  ADC OS pins
- ad_range  out  1  ADC RANGE pin
- ad_reset  out  1  ADC RESET pin
- ad_convst  out  1  ADC CONVST A/B, active low
- ad_cs  out  1  ADC CS, active low
- ad_rd  out  1  ADC RD, active low
- dout  out  16  sample word
- dout_ch  out  3  channel index of dout (0 = CH1)
- dout_valid  out  1  one-cycle strobe, dout/dout_ch valid
- frame_done  out  1  one-cycle pulse after last channel of a frame
- ctrl_busy  out  1  high in every state except IDLE
- err_tmo  out  1  sticky busy-timeout flag
- err_first  out  1  sticky first-data mismatch flag
REQ-003 Clock/reset: one clock; reset is asynchronous and active-high.

Function
REQ-004 States: POR, IDLE, CONV, WAIT1, WAIT_BUSY, RD_LO, RD_HI, DONE; one shared cycle counter, one channel counter.
REQ-005 POR: ad_reset=1 for exactly T_RST cycles after rst deasserts, then ad_reset=0 and -> IDLE.
REQ-006 IDLE: cs=rd=convst=1; os_cfg/range_cfg sampled into ad_os/ad_range only here (changes mid-frame ignored); after >=T_IDLE cycles in IDLE, go to CONV if cont_en=1 or a start pulse is pending.
REQ-007 start pulses arriving in any state other than IDLE are latched as one pending request; multiple pulses collapse to one.
REQ-008 CONV: convst=0 for exactly T_CONV cycles, then convst=1, -> WAIT1.
REQ-009 WAIT1: T_WAIT cycles, -> WAIT_BUSY.
REQ-010 WAIT_BUSY: first cycle ad_busy=0 -> RD_LO with channel counter 0; if busy stays 1 for T_TMO cycles -> DONE, err_tmo=1, no dout_valid, no frame_done.
REQ-011 RD_LO: cs=0, rd=0 for T_RD_LO cycles; on last cycle capture ad_data into dout, dout_ch=channel counter, dout_valid=1 next cycle.
REQ-012 On channel 0 capture, ad_first=0 sets err_first; on channels 1..CH_NUM-1, ad_first=1 sets err_first; data still delivered.
REQ-013 RD_HI: cs=0, rd=1 for T_RD_HI cycles; if channel counter = CH_NUM-1 -> DONE, else increment, -> RD_LO.
REQ-014 DONE: one cycle, cs=rd=1, frame_done=1 (only on completed frame), -> IDLE.
REQ-015 err_tmo/err_first hold until err_clr=1; simultaneous set and clear: set wins.
REQ-016 cont_en dropping mid-frame completes the current frame, then idles.
REQ-017 Exactly CH_NUM dout_valid strobes per completed frame, dout_ch ascending 0..CH_NUM-1.

Reset
REQ-018 rst=1 forces state POR, counters 0, ad_reset=1, cs=rd=convst=1, ad_os=000, ad_range=1, dout=0, dout_ch=0, dout_valid=0, frame_done=0, err flags 0, pending start cleared, ctrl_busy=1, immediately and regardless of clk.
REQ-019 rst asserted mid-read aborts the frame with no further dout_valid; POR sequence restarts on release.

Verification
REQ-020 rst release, T_RST=16 -> ad_reset high exactly 16 cycles, ctrl_busy low thereafter.
REQ-021 cont_en=0, start pulse, ADC model busy 50 cycles, data 0x1000+ch, CH_NUM=8 -> 8 strobes 0x1000..0x1007, dout_ch 0..7, one frame_done.
REQ-022 CH_NUM=3, cont_en=1, 3 frames -> 9 strobes, frame spacing constant, rd low 4 / high 2 cycles.
REQ-023 busy held high, T_TMO=32 -> err_tmo=1 at cycle 32 of WAIT_BUSY, no strobes; err_clr -> err_tmo=0.
REQ-024 ad_first=0 on channel 0 -> err_first=1, all 8 strobes still issued.
REQ-025 rst pulse during RD_LO of channel 4; os_cfg=101 changed mid-frame -> no strobe after rst, outputs at reset values; ad_os updates only at next IDLE.
